// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 execute stage: ALU opcodes, forward-select
// codes, the multiplier state encoding and the latched control bundle.
package legv8_pkg;

  localparam int DATA_W_DEFAULT = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_EOR   = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_LSL   = 4'b1000;
  localparam logic [3:0] ALU_LSR   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [4:0] rd;
  } ex_ctrl_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle;
// operands are captured on start so later operand changes are ignored.
module seq_multiplier
  import legv8_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_idle,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int N     = DATA_W / MUL_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mul_state_t        r_state;
  mul_state_t        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_pp [MUL_BITS];
  logic [DATA_W-1:0] w_step_sum;
  logic              w_last;
  logic              w_accept;

  assign w_last   = (r_cnt == CNT_W'(N - 1));
  assign w_accept = (r_state == MUL_IDLE) && i_start && !i_abort;

  // One partial product per multiplier bit retired this cycle.
  for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
    assign w_pp[gi] = r_b[gi] ? (r_a << gi) : '0;
  end

  always_comb begin
    w_step_sum = r_acc;
    for (int k = 0; k < MUL_BITS; k++) begin
      w_step_sum = w_step_sum + w_pp[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MUL_IDLE: if (w_accept) w_state_next = MUL_BUSY;
      MUL_BUSY: if (w_last) w_state_next = MUL_DONE;
      MUL_DONE: w_state_next = MUL_IDLE;
      default:  w_state_next = MUL_IDLE;
    endcase
    if (i_abort) begin
      w_state_next = MUL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_a   <= i_op_a;
      r_b   <= i_op_b;
      r_acc <= '0;
    end else if (r_state == MUL_BUSY && !i_abort) begin
      r_acc <= w_step_sum;
      r_a   <= r_a << MUL_BITS;
      r_b   <= r_b >> MUL_BITS;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end else if (i_abort) begin
      r_cnt <= '0;
    end
  end

  assign o_idle    = (r_state == MUL_IDLE);
  assign o_busy    = (r_state == MUL_BUSY);
  assign o_done    = (r_state == MUL_DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// LEGv8 EX stage: operand forwarding, inline ALU, branch target adder, an
// iterative multiplier that stalls the front end, and the EX/MEM register.
module execute_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_EX_Valid,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_MemtoReg,
  input  logic              ID_EX_Branch,
  input  logic              ID_EX_ALUSrc,
  input  logic [3:0]        ID_EX_ALUOp,
  input  logic [4:0]        ID_EX_RegisterRd,
  input  logic [DATA_W-1:0] ID_EX_PC,
  input  logic [DATA_W-1:0] ID_EX_ReadData1,
  input  logic [DATA_W-1:0] ID_EX_ReadData2,
  input  logic [DATA_W-1:0] ID_EX_SignExtImm,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] WB_WriteData,
  input  logic              flush,
  output logic              ex_stall,
  output logic              EX_MEM_Valid,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_MemWrite,
  output logic              EX_MEM_MemtoReg,
  output logic              EX_MEM_Branch,
  output logic              EX_MEM_Zero,
  output logic [4:0]        EX_MEM_RegisterRd,
  output logic [DATA_W-1:0] EX_MEM_ALUResult,
  output logic [DATA_W-1:0] EX_MEM_WriteData,
  output logic [DATA_W-1:0] EX_MEM_BranchTarget
);

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_branch_target;
  logic [DATA_W-1:0] w_product;
  logic              w_mul_idle;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic              w_mul_start;
  logic              w_bubble;

  ex_ctrl_t          r_mul_ctrl;
  logic [DATA_W-1:0] r_mul_store;
  logic [DATA_W-1:0] r_mul_target;

  always_comb begin
    case (ForwardA)
      FWD_EXMEM: w_op_a = EX_MEM_ALUResult;
      FWD_WB:    w_op_a = WB_WriteData;
      default:   w_op_a = ID_EX_ReadData1;
    endcase
    case (ForwardB)
      FWD_EXMEM: w_fwd_b = EX_MEM_ALUResult;
      FWD_WB:    w_fwd_b = WB_WriteData;
      default:   w_fwd_b = ID_EX_ReadData2;
    endcase
  end

  assign w_op_b          = ID_EX_ALUSrc ? ID_EX_SignExtImm : w_fwd_b;
  assign w_branch_target = ID_EX_PC + (ID_EX_SignExtImm << 2);

  // MUL yields 0 here; its result only enters EX/MEM from the multiplier.
  always_comb begin
    w_alu_result = '0;
    case (ID_EX_ALUOp)
      ALU_AND:   w_alu_result = w_op_a & w_op_b;
      ALU_ORR:   w_alu_result = w_op_a | w_op_b;
      ALU_ADD:   w_alu_result = w_op_a + w_op_b;
      ALU_SUB:   w_alu_result = w_op_a - w_op_b;
      ALU_PASSB: w_alu_result = w_op_b;
      ALU_EOR:   w_alu_result = w_op_a ^ w_op_b;
      ALU_NOR:   w_alu_result = ~(w_op_a | w_op_b);
      ALU_LSL:   w_alu_result = w_op_a << w_op_b[5:0];
      ALU_LSR:   w_alu_result = w_op_a >> w_op_b[5:0];
      default:   w_alu_result = '0;
    endcase
  end

  assign w_mul_start = ID_EX_Valid && (ID_EX_ALUOp == ALU_MUL) && !flush && w_mul_idle;
  assign ex_stall    = !reset && !flush && (w_mul_start || w_mul_busy);
  assign w_bubble    = flush || ex_stall || !(w_mul_done || ID_EX_Valid);

  seq_multiplier #(
    .DATA_W   (DATA_W),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_abort   (flush),
    .i_op_a    (w_op_a),
    .i_op_b    (w_op_b),
    .o_idle    (w_mul_idle),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Control, store data and target are captured with the operands so the
  // writeback does not depend on what ID/EX holds when the product is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_ctrl   <= '0;
      r_mul_store  <= '0;
      r_mul_target <= '0;
    end else if (w_mul_start) begin
      r_mul_ctrl   <= '{ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
                        ID_EX_MemtoReg, ID_EX_Branch, ID_EX_RegisterRd};
      r_mul_store  <= w_fwd_b;
      r_mul_target <= w_branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      EX_MEM_Valid        <= 1'b0;
      EX_MEM_RegWrite     <= 1'b0;
      EX_MEM_MemRead      <= 1'b0;
      EX_MEM_MemWrite     <= 1'b0;
      EX_MEM_MemtoReg     <= 1'b0;
      EX_MEM_Branch       <= 1'b0;
      EX_MEM_Zero         <= 1'b0;
      EX_MEM_RegisterRd   <= '0;
      EX_MEM_ALUResult    <= '0;
      EX_MEM_WriteData    <= '0;
      EX_MEM_BranchTarget <= '0;
    end else if (w_bubble) begin
      EX_MEM_Valid        <= 1'b0;
      EX_MEM_RegWrite     <= 1'b0;
      EX_MEM_MemRead      <= 1'b0;
      EX_MEM_MemWrite     <= 1'b0;
      EX_MEM_MemtoReg     <= ID_EX_MemtoReg;
      EX_MEM_Branch       <= 1'b0;
      EX_MEM_Zero         <= (w_alu_result == '0);
      EX_MEM_RegisterRd   <= ID_EX_RegisterRd;
      EX_MEM_ALUResult    <= w_alu_result;
      EX_MEM_WriteData    <= w_fwd_b;
      EX_MEM_BranchTarget <= w_branch_target;
    end else if (w_mul_done) begin
      EX_MEM_Valid        <= 1'b1;
      EX_MEM_RegWrite     <= r_mul_ctrl.reg_write;
      EX_MEM_MemRead      <= r_mul_ctrl.mem_read;
      EX_MEM_MemWrite     <= r_mul_ctrl.mem_write;
      EX_MEM_MemtoReg     <= r_mul_ctrl.mem_to_reg;
      EX_MEM_Branch       <= r_mul_ctrl.branch;
      EX_MEM_Zero         <= (w_product == '0);
      EX_MEM_RegisterRd   <= r_mul_ctrl.rd;
      EX_MEM_ALUResult    <= w_product;
      EX_MEM_WriteData    <= r_mul_store;
      EX_MEM_BranchTarget <= r_mul_target;
    end else begin
      EX_MEM_Valid        <= 1'b1;
      EX_MEM_RegWrite     <= ID_EX_RegWrite;
      EX_MEM_MemRead      <= ID_EX_MemRead;
      EX_MEM_MemWrite     <= ID_EX_MemWrite;
      EX_MEM_MemtoReg     <= ID_EX_MemtoReg;
      EX_MEM_Branch       <= ID_EX_Branch;
      EX_MEM_Zero         <= (w_alu_result == '0);
      EX_MEM_RegisterRd   <= ID_EX_RegisterRd;
      EX_MEM_ALUResult    <= w_alu_result;
      EX_MEM_WriteData    <= w_fwd_b;
      EX_MEM_BranchTarget <= w_branch_target;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations;
// one line per checked transaction.
module tb_execute_stage;
  import legv8_pkg::*;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
  logic          ID_EX_MemtoReg, ID_EX_Branch, ID_EX_ALUSrc;
  logic [3:0]    ID_EX_ALUOp;
  logic [4:0]    ID_EX_RegisterRd;
  logic [DW-1:0] ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic [1:0]    ForwardA, ForwardB;
  logic [DW-1:0] WB_WriteData;
  logic          flush;
  logic          ex_stall;
  logic          EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic          EX_MEM_MemtoReg, EX_MEM_Branch, EX_MEM_Zero;
  logic [4:0]    EX_MEM_RegisterRd;
  logic [DW-1:0] EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_BranchTarget;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(DW), .MUL_BITS(1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ID_EX_Valid         (ID_EX_Valid),
    .ID_EX_RegWrite      (ID_EX_RegWrite),
    .ID_EX_MemRead       (ID_EX_MemRead),
    .ID_EX_MemWrite      (ID_EX_MemWrite),
    .ID_EX_MemtoReg      (ID_EX_MemtoReg),
    .ID_EX_Branch        (ID_EX_Branch),
    .ID_EX_ALUSrc        (ID_EX_ALUSrc),
    .ID_EX_ALUOp         (ID_EX_ALUOp),
    .ID_EX_RegisterRd    (ID_EX_RegisterRd),
    .ID_EX_PC            (ID_EX_PC),
    .ID_EX_ReadData1     (ID_EX_ReadData1),
    .ID_EX_ReadData2     (ID_EX_ReadData2),
    .ID_EX_SignExtImm    (ID_EX_SignExtImm),
    .ForwardA            (ForwardA),
    .ForwardB            (ForwardB),
    .WB_WriteData        (WB_WriteData),
    .flush               (flush),
    .ex_stall            (ex_stall),
    .EX_MEM_Valid        (EX_MEM_Valid),
    .EX_MEM_RegWrite     (EX_MEM_RegWrite),
    .EX_MEM_MemRead      (EX_MEM_MemRead),
    .EX_MEM_MemWrite     (EX_MEM_MemWrite),
    .EX_MEM_MemtoReg     (EX_MEM_MemtoReg),
    .EX_MEM_Branch       (EX_MEM_Branch),
    .EX_MEM_Zero         (EX_MEM_Zero),
    .EX_MEM_RegisterRd   (EX_MEM_RegisterRd),
    .EX_MEM_ALUResult    (EX_MEM_ALUResult),
    .EX_MEM_WriteData    (EX_MEM_WriteData),
    .EX_MEM_BranchTarget (EX_MEM_BranchTarget)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    ID_EX_Valid      = 1'b0;
    ID_EX_RegWrite   = 1'b0;
    ID_EX_MemRead    = 1'b0;
    ID_EX_MemWrite   = 1'b0;
    ID_EX_MemtoReg   = 1'b0;
    ID_EX_Branch     = 1'b0;
    ID_EX_ALUSrc     = 1'b0;
    ID_EX_ALUOp      = ALU_AND;
    ID_EX_RegisterRd = 5'd0;
    ID_EX_PC         = '0;
    ID_EX_ReadData1  = '0;
    ID_EX_ReadData2  = '0;
    ID_EX_SignExtImm = '0;
    ForwardA         = 2'b00;
    ForwardB         = 2'b00;
    WB_WriteData     = '0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    idle_in();
    ID_EX_Valid      = 1'b1;
    ID_EX_RegWrite   = 1'b1;
    ID_EX_ALUOp      = op;
    ID_EX_RegisterRd = 5'd3;
    ID_EX_ReadData1  = a;
    ID_EX_ReadData2  = b;
  endtask

  task automatic mul_in(input logic [63:0] a, input logic [63:0] b);
    alu_op(ALU_MUL, a, b);
    ID_EX_RegisterRd = 5'd9;
  endtask

  int stalls;
  bit bubble_bad;
  bit leak;

  initial begin
    flush = 1'b0;
    reset = 1'b1;
    mul_in(64'd7, 64'd6);
    #1;
    chk("reset_cycle_stall", 64'(ex_stall), 64'd0);
    step();
    step();
    chk("reset_ctrl", 64'({EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_Zero, EX_MEM_RegisterRd}), 64'd0);
    chk("reset_alu", EX_MEM_ALUResult, 64'd0);
    reset = 1'b0;

    // Forwarding from EX/MEM.
    alu_op(ALU_ADD, 64'd2, 64'd3);
    step();
    chk("add_seed", EX_MEM_ALUResult, 64'd5);
    alu_op(ALU_ADD, 64'd99, 64'd7);
    ForwardA = 2'b10;
    step();
    chk("add_fwd_exmem", EX_MEM_ALUResult, 64'd12);
    chk("add_fwd_zero", 64'(EX_MEM_Zero), 64'd0);
    chk("add_valid_rw", 64'({EX_MEM_Valid, EX_MEM_RegWrite}), 64'd3);

    // STUR address with WB-forwarded store data.
    idle_in();
    ID_EX_Valid      = 1'b1;
    ID_EX_MemWrite   = 1'b1;
    ID_EX_ALUSrc     = 1'b1;
    ID_EX_ALUOp      = ALU_ADD;
    ID_EX_SignExtImm = 64'd8;
    ID_EX_ReadData1  = 64'h100;
    ID_EX_ReadData2  = 64'h999;
    ForwardB         = 2'b01;
    WB_WriteData     = 64'h55;
    ID_EX_PC         = 64'h1000;
    step();
    chk("stur_addr", EX_MEM_ALUResult, 64'h108);
    chk("stur_data", EX_MEM_WriteData, 64'h55);
    chk("stur_memwrite_rw", 64'({EX_MEM_MemWrite, EX_MEM_RegWrite}), 64'd2);
    chk("stur_target", EX_MEM_BranchTarget, 64'h1020);

    alu_op(ALU_SUB, 64'd9, 64'd9);
    step();
    chk("sub_result", EX_MEM_ALUResult, 64'd0);
    chk("sub_zero", 64'(EX_MEM_Zero), 64'd1);

    alu_op(ALU_LSL, 64'd1, 64'd68);
    step();
    chk("lsl_mod64", EX_MEM_ALUResult, 64'd16);

    alu_op(ALU_ADD, 64'd3, 64'd4);
    ForwardA     = 2'b11;
    WB_WriteData = 64'd100;
    step();
    chk("fwd11_rf", EX_MEM_ALUResult, 64'd7);

    alu_op(ALU_EOR, 64'hF0, 64'hFF);
    step();
    chk("eor", EX_MEM_ALUResult, 64'h0F);
    alu_op(ALU_NOR, 64'd0, 64'd0);
    step();
    chk("nor", EX_MEM_ALUResult, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_op(ALU_LSR, 64'h100, 64'd4);
    step();
    chk("lsr", EX_MEM_ALUResult, 64'h10);
    alu_op(ALU_ORR, 64'hA0, 64'h05);
    step();
    chk("orr", EX_MEM_ALUResult, 64'hA5);
    alu_op(ALU_AND, 64'hF0, 64'h3C);
    step();
    chk("and", EX_MEM_ALUResult, 64'h30);
    alu_op(ALU_PASSB, 64'd5, 64'd0);
    step();
    chk("cbz_zero", 64'({EX_MEM_Zero, EX_MEM_ALUResult[7:0]}), 64'h100);
    alu_op(4'b0011, 64'd5, 64'd5);
    step();
    chk("undef_op", EX_MEM_ALUResult, 64'd0);
    alu_op(ALU_ADD, 64'd1, 64'd1);
    ID_EX_Valid = 1'b0;
    step();
    chk("invalid_bubble", 64'({EX_MEM_Valid, EX_MEM_RegWrite}), 64'd0);

    // MUL 7x6 with forwarding disturbed mid-BUSY.
    mul_in(64'd7, 64'd6);
    #1;
    chk("mul_first_stall", 64'(ex_stall), 64'd1);
    stalls = 0;
    bubble_bad = 1'b0;
    for (int c = 0; c < 200 && ex_stall; c++) begin
      stalls++;
      if (c == 10) begin
        ForwardA     = 2'b01;
        ForwardB     = 2'b10;
        WB_WriteData = 64'd1000;
      end
      step();
      if (EX_MEM_Valid || EX_MEM_RegWrite) bubble_bad = 1'b1;
    end
    chk("mul_stall_cycles", 64'(stalls), 64'd65);
    chk("mul_bubbles", 64'(bubble_bad), 64'd0);
    step();
    chk("mul_product", EX_MEM_ALUResult, 64'd42);
    chk("mul_ctrl", 64'({EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_RegisterRd}), 64'h69);
    idle_in();
    #1;
    chk("mul_after_stall", 64'(ex_stall), 64'd0);
    step();
    chk("mul_no_repeat", 64'(EX_MEM_Valid), 64'd0);

    // Flush on the 10th BUSY cycle.
    mul_in(64'd3, 64'd5);
    step();
    repeat (9) step();
    flush = 1'b1;
    #1;
    chk("flush_stall_low", 64'(ex_stall), 64'd0);
    step();
    chk("flush_bubble", 64'(EX_MEM_Valid), 64'd0);
    flush = 1'b0;
    idle_in();
    #1;
    chk("flush_fsm_idle", 64'(ex_stall), 64'd0);
    alu_op(ALU_ADD, 64'd2, 64'd2);
    step();
    chk("flush_next_add", 64'({EX_MEM_Valid, EX_MEM_ALUResult[7:0]}), 64'h104);

    // Flush arriving together with a MUL.
    mul_in(64'd3, 64'd5);
    flush = 1'b1;
    #1;
    chk("flush_mul_stall", 64'(ex_stall), 64'd0);
    step();
    chk("flush_mul_bubble", 64'(EX_MEM_Valid), 64'd0);
    flush = 1'b0;
    idle_in();
    #1;
    chk("flush_mul_no_busy", 64'(ex_stall), 64'd0);

    // Reset in the middle of BUSY.
    mul_in(64'd7, 64'd6);
    step();
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("rst_busy_stall", 64'(ex_stall), 64'd0);
    step();
    reset = 1'b0;
    idle_in();
    #1;
    chk("rst_busy_stall_after", 64'(ex_stall), 64'd0);
    chk("rst_busy_ctrl", 64'({EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite,
                              EX_MEM_MemtoReg, EX_MEM_Branch, EX_MEM_Zero, EX_MEM_RegisterRd}), 64'd0);
    chk("rst_busy_data", EX_MEM_WriteData | EX_MEM_ALUResult | EX_MEM_BranchTarget, 64'd0);
    leak = 1'b0;
    repeat (70) begin
      step();
      if (EX_MEM_Valid || EX_MEM_ALUResult == 64'd42) leak = 1'b1;
    end
    chk("rst_busy_no_writeback", 64'(leak), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
